// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data load/store. Data has fixed priority over fetch. All memory-side
// outputs and completion pulses are registered; stall is combinational.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_rd_en,
    input  logic        d_wr_en,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_err,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [9:0] TIMEOUT_W = 10'(TIMEOUT);

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        d_valid_q, d_valid_d;
    logic        d_err_q, d_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [9:0]  wait_cnt_q, wait_cnt_d;

    logic        d_pend;
    logic        i_pend;
    logic        d_misaligned;
    logic [3:0]  d_be;
    logic [31:0] d_lane_wdata;
    logic [9:0]  wait_inc;
    logic        timeout_hit;

    // A requester whose completion pulse is showing this cycle is not pending,
    // so a slow-to-drop request is never granted twice.
    assign d_pend      = (d_rd_en | d_wr_en) & ~d_valid_q;
    assign i_pend      = if_req & ~if_valid_q;
    assign stall       = i_pend | d_pend;
    assign wait_inc    = wait_cnt_q + 10'd1;
    assign timeout_hit = (wait_inc == TIMEOUT_W);

    // Decode data access size into byte enables, replicated store lanes and
    // an alignment error flag.
    always_comb begin
        d_be         = 4'b1111;
        d_lane_wdata = d_wdata;
        d_misaligned = 1'b0;
        case (d_size)
            2'b00: begin
                d_be         = 4'b0001 << d_addr[1:0];
                d_lane_wdata = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                d_be         = 4'b0011 << {d_addr[1], 1'b0};
                d_lane_wdata = {2{d_wdata[15:0]}};
                d_misaligned = d_addr[0];
            end
            default: begin
                d_misaligned = |d_addr[1:0];
            end
        endcase
    end

    // Next-state and registered-output logic: grant in IDLE, then wait for
    // ack or timeout in the busy states.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        wait_cnt_d  = wait_cnt_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_pend) begin
                    if (d_misaligned) begin
                        d_valid_d = 1'b1;
                        d_err_d   = 1'b1;
                    end else begin
                        state_d     = BUSY_D;
                        mem_req_d   = 1'b1;
                        mem_we_d    = d_wr_en;
                        mem_addr_d  = {d_addr[31:2], 2'b00};
                        mem_be_d    = d_be;
                        mem_wdata_d = d_lane_wdata;
                        wait_cnt_d  = 10'd0;
                    end
                end else if (i_pend) begin
                    state_d     = BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_be_d    = 4'b1111;
                    mem_wdata_d = 32'd0;
                    wait_cnt_d  = 10'd0;
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = mem_rdata;
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = 32'd0;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_valid_d = 1'b1;
                    d_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything and aborts any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= 32'd0;
            wait_cnt_q  <= 10'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (TIMEOUT=4 so the timeout path
// is reachable within a few cycles).
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_rd_en;
    logic        d_wr_en;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_rd_en   (d_rd_en),
        .d_wr_en   (d_wr_en),
        .d_addr    (d_addr),
        .d_size    (d_size),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_err     (d_err),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a data request onto the data port.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                  input logic [1:0] size, input logic [31:0] wdata);
        d_rd_en = rd;
        d_wr_en = wr;
        d_addr  = addr;
        d_size  = size;
        d_wdata = wdata;
    endtask

    // Directed sequence of scenarios.
    initial begin
        rst_n = 1'b1; if_req = 0; if_addr = 0; mem_ack = 0; mem_rdata = 0;
        apply_stimulus(0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        tick(); tick();
        check_output("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_output("rst_mem_addr", mem_addr, 32'd0);
        check_output("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check_output("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
        check_output("rst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Fetch 0x100, ack two cycles after mem_req rises.
        if_req = 1; if_addr = 32'h100;
        #1 check_output("fetch_stall", {31'd0, stall}, 32'd1);
        tick();
        check_output("fetch_req", {31'd0, mem_req}, 32'd1);
        check_output("fetch_addr", mem_addr, 32'h100);
        check_output("fetch_we", {31'd0, mem_we}, 32'd0);
        tick();
        check_output("fetch_req_hold", {31'd0, mem_req}, 32'd1);
        mem_ack = 1; mem_rdata = 32'h00500093;
        tick();
        mem_ack = 0;
        check_output("fetch_valid", {31'd0, if_valid}, 32'd1);
        check_output("fetch_rdata", if_rdata, 32'h00500093);
        check_output("fetch_req_drop", {31'd0, mem_req}, 32'd0);
        check_output("fetch_stall_done", {31'd0, stall}, 32'd0);
        if_req = 0;
        tick();
        check_output("fetch_valid_pulse", {31'd0, if_valid}, 32'd0);

        // Fetch and word load together: load wins, fetch follows after one idle cycle.
        if_req = 1; if_addr = 32'h200;
        apply_stimulus(1, 0, 32'h2004, 2'b10, 0);
        tick();
        check_output("prio_addr", mem_addr, 32'h2004);
        check_output("prio_we", {31'd0, mem_we}, 32'd0);
        check_output("prio_be", {28'd0, mem_be}, 32'hF);
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 0;
        check_output("load_valid", {31'd0, d_valid}, 32'd1);
        check_output("load_rdata", d_rdata, 32'hDEADBEEF);
        check_output("load_err", {31'd0, d_err}, 32'd0);
        check_output("load_req_drop", {31'd0, mem_req}, 32'd0);
        d_rd_en = 0;
        tick();
        check_output("prio_fetch_req", {31'd0, mem_req}, 32'd1);
        check_output("prio_fetch_addr", mem_addr, 32'h200);
        mem_ack = 1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 0;
        check_output("prio_fetch_valid", {31'd0, if_valid}, 32'd1);
        if_req = 0;
        tick();

        // Byte store with both enables high (treated as a store).
        apply_stimulus(1, 1, 32'h3003, 2'b00, 32'h000000AB);
        tick();
        check_output("sb_be", {28'd0, mem_be}, 32'h8);
        check_output("sb_wdata", mem_wdata, 32'hABABABAB);
        check_output("sb_we", {31'd0, mem_we}, 32'd1);
        check_output("sb_addr", mem_addr, 32'h3000);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        check_output("sb_valid", {31'd0, d_valid}, 32'd1);
        check_output("sb_rdata_kept", d_rdata, 32'hDEADBEEF);
        apply_stimulus(0, 0, 0, 0, 0);
        tick();

        // Half store to the upper half of a word.
        apply_stimulus(0, 1, 32'h3002, 2'b01, 32'h00001234);
        tick();
        check_output("sh_be", {28'd0, mem_be}, 32'hC);
        check_output("sh_wdata", mem_wdata, 32'h12341234);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        apply_stimulus(0, 0, 0, 0, 0);
        tick();

        // Misaligned half load: no memory request, error completion.
        apply_stimulus(1, 0, 32'h3001, 2'b01, 0);
        tick();
        check_output("mis_req", {31'd0, mem_req}, 32'd0);
        check_output("mis_valid", {31'd0, d_valid}, 32'd1);
        check_output("mis_err", {31'd0, d_err}, 32'd1);
        apply_stimulus(0, 0, 0, 0, 0);
        tick();
        check_output("mis_err_clear", {30'd0, d_valid, d_err}, 32'd0);

        // Ack while idle is ignored.
        mem_ack = 1;
        tick();
        mem_ack = 0;
        check_output("idle_ack", {29'd0, mem_req, if_valid, d_valid}, 32'd0);

        // Load with no ack: request for 4 cycles, then error completion.
        apply_stimulus(1, 0, 32'h4000, 2'b10, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output($sformatf("to_req_%0d", i), {31'd0, mem_req}, 32'd1);
            check_output($sformatf("to_novalid_%0d", i), {31'd0, d_valid}, 32'd0);
        end
        tick();
        check_output("to_req_drop", {31'd0, mem_req}, 32'd0);
        check_output("to_valid", {31'd0, d_valid}, 32'd1);
        check_output("to_err", {31'd0, d_err}, 32'd1);
        apply_stimulus(0, 0, 0, 0, 0);
        tick();

        // Fetch timeout returns zero data.
        if_req = 1; if_addr = 32'h400;
        repeat (5) tick();
        check_output("fto_valid", {31'd0, if_valid}, 32'd1);
        check_output("fto_rdata", if_rdata, 32'd0);
        check_output("fto_derr", {31'd0, d_err}, 32'd0);
        if_req = 0;
        tick();

        // Reset during a data access drops the request and discards it.
        apply_stimulus(1, 0, 32'h5000, 2'b10, 0);
        tick();
        check_output("rb_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_output("rb_async_drop", {31'd0, mem_req}, 32'd0);
        apply_stimulus(0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        mem_ack = 1;
        tick();
        mem_ack = 0;
        tick();
        check_output("rb_no_valid", {30'd0, d_valid, mem_req}, 32'd0);

        // First grant after reset release.
        apply_stimulus(1, 0, 32'h6000, 2'b10, 0);
        tick();
        check_output("rb_new_req", {31'd0, mem_req}, 32'd1);
        check_output("rb_new_addr", mem_addr, 32'h6000);
        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 0;
        check_output("rb_new_rdata", d_rdata, 32'hCAFEF00D);
        apply_stimulus(0, 0, 0, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 Parameter TIMEOUT, default 255: maximum wait for mem_ack, in cycles (1..1023).
REQ-003 clk  in  1  system clock; rising edge active.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 if_req  in  1  instruction fetch request; held high until if_valid.
REQ-006 if_addr  in  32  fetch address; word aligned.
REQ-007 if_rdata  out  32  fetched instruction word.
REQ-008 if_valid  out  1  one-cycle fetch completion pulse.
REQ-009 d_rd_en  in  1  load request (from control unit mem_read_en); held high until d_valid.
REQ-010 d_wr_en  in  1  store request (from control unit mem_write_en); held high until d_valid.
REQ-011 d_addr  in  32  load/store byte address.
REQ-012 d_size  in  2  access size: 00 byte, 01 half, 10 word, 11 word.
REQ-013 d_wdata  in  32  store data, right-justified.
REQ-014 d_rdata  out  32  raw memory word returned for a load.
REQ-015 d_valid  out  1  one-cycle data completion pulse.
REQ-016 d_err  out  1  qualifies d_valid: misaligned access or timeout.
REQ-017 stall  out  1  freezes the PC and register-file write while any request is outstanding.
REQ-018 mem_req, mem_we  out  1 each  single-port memory request and write strobe.
REQ-019 mem_addr  out  32  word address {d_addr[31:2],2'b00} or if_addr.
REQ-020 mem_wdata  out  32  lane-replicated store data.
REQ-021 mem_be  out  4  byte enables.
REQ-022 mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle.
REQ-023 mem_rdata  in  32  memory read data.

Function
REQ-024 FSM states SHALL be IDLE, BUSY_I and BUSY_D; all mem_* outputs are registered.
REQ-025 IDLE SHALL grant data over fetch when both are pending (fixed priority); data → BUSY_D, fetch → BUSY_I.
REQ-026 A request sampled in IDLE at edge N SHALL drive mem_req=1 from N+1, holding address, we, be and wdata stable until mem_ack.
REQ-027 mem_ack sampled at edge M SHALL deassert mem_req, capture mem_rdata and pulse if_valid or d_valid in cycle M+1, and return to IDLE.
REQ-028 Back-to-back grants: the earliest next mem_req SHALL occur at M+2 (one IDLE cycle).
REQ-029 If d_rd_en and d_wr_en are both high, the access SHALL be treated as a store.
REQ-030 mem_be SHALL be 0001<<addr[1:0] for a byte, 0011<<{addr[1],0} for a half, and 1111 for a word.
REQ-031 mem_wdata SHALL be {4{wdata[7:0]}} for a byte, {2{wdata[15:0]}} for a half, and wdata for a word.
REQ-032 A misaligned access (half with addr[0]=1, or word with addr[1:0]≠0) SHALL raise no mem_req and SHALL give d_valid=1 and d_err=1 one cycle after the grant.
REQ-033 A 10-bit wait counter SHALL clear on entry to a BUSY state and increment on each cycle without ack.
REQ-034 When the wait counter reaches TIMEOUT, the block SHALL drop mem_req, pulse valid with d_err=1 (fetch: if_valid with if_rdata=0) and return to IDLE.
REQ-035 mem_ack received while in IDLE SHALL be ignored.
REQ-036 stall SHALL equal (if_req & ~if_valid) | ((d_rd_en|d_wr_en) & ~d_valid), combinationally.
REQ-037 d_err SHALL be 0 whenever d_valid is 0.
REQ-038 A requester dropping its request mid-access SHALL NOT abort the access; completion is still pulsed.

Reset
REQ-039 While rst_n=0, the block SHALL be in IDLE with every output 0 (mem_*, if_*, d_*), the wait counter at 0, and all captured data at 0.
REQ-040 Reset asserted mid-access SHALL drop mem_req asynchronously and discard the pending access; no valid pulse follows.
REQ-041 The first grant after reset deassertion SHALL occur at the first rising edge on which rst_n=1 and a request is high.

Verification
REQ-042 Fetch if_addr=0x100, ack 2 cycles after mem_req, mem_rdata=0x00500093 -> if_valid=1 for one cycle, if_rdata=0x00500093.
REQ-043 Fetch and load (d_addr=0x2004, word) raised in the same cycle -> the load is granted first, mem_addr=0x2004, then the fetch after one IDLE cycle.
REQ-044 Byte store d_addr=0x3003, d_wdata=0xAB -> mem_be=1000, mem_wdata=0xABABABAB, mem_we=1.
REQ-045 Half load d_addr=0x3001 -> no mem_req, then d_valid=1 and d_err=1 one cycle after the grant.
REQ-046 Load with TIMEOUT=4 and mem_ack held low -> mem_req high for 4 cycles, then d_valid=1 and d_err=1.
REQ-047 rst_n pulled low during BUSY_D -> mem_req=0 immediately, and after release no d_valid occurs until a new request.
